// File: rtl/fp16_quot_normalizer_if.sv
// ============================================================================
// fp16_quot_normalizer_if
// Upstream quotient handshake and downstream binary16 result bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fp16_quot_normalizer_if #(
    parameter int MW = 24
);
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [6:0]    in_exp;
    logic [MW-1:0] in_mant;
    logic [1:0]    in_class;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_result;
    logic          out_overflow;
    logic          out_underflow;
    logic          out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );
endinterface

`default_nettype wire

// File: rtl/fp16_quot_normalizer.sv
// ============================================================================
// fp16_quot_normalizer
// Normalizes a raw divider quotient one shift per cycle, rounds to nearest
// even and packs an IEEE-754 binary16 result with exception flags.
// Optional macro FP16_SUBNORMAL_EN enables gradual underflow (DENORM state).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp16_quot_normalizer #(
    parameter int MW = 24
) (
    input  wire                   clk,
    input  wire                   reset_n,
    fp16_quot_normalizer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NORM   = 3'd1,
        S_DENORM = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0]        c_cls_normal = 2'b00;
    localparam logic [1:0]        c_cls_zero   = 2'b01;
    localparam logic [1:0]        c_cls_inf    = 2'b10;
    localparam logic [1:0]        c_cls_nan    = 2'b11;
    localparam logic signed [8:0] c_bias       = 9'sd15;
`ifdef FP16_SUBNORMAL_EN
    localparam logic signed [8:0] c_exp_min    = -9'sd14;
`endif

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic signed [8:0]     exp_q, exp_d;
    logic [MW-1:0]         mant_q, mant_d;
    logic                  sticky_q, sticky_d;
    logic [1:0]            cls_q, cls_d;
    logic [15:0]           result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  inx_q, inx_d;
`ifdef FP16_SUBNORMAL_EN
    logic [3:0]            cnt_q, cnt_d;
`endif

    logic [9:0]            frac_w;
    logic                  guard_w;
    logic                  sticky_w;
    logic                  round_up_w;
    logic [10:0]           frac_sum_w;
    logic                  carry_w;
    logic signed [8:0]     biased_w;
    logic                  inexact_w;

    // Rounding datapath; only meaningful while in S_ROUND.
    always_comb begin
        frac_w     = mant_q[MW-3:MW-12];
        guard_w    = mant_q[MW-13];
        sticky_w   = (|mant_q[MW-14:0]) | sticky_q;
        round_up_w = guard_w & (sticky_w | frac_w[0]);
        frac_sum_w = {1'b0, frac_w} + {10'd0, round_up_w};
        carry_w    = frac_sum_w[10];
        biased_w   = exp_q + c_bias + $signed({8'd0, carry_w});
        inexact_w  = guard_w | sticky_w;
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        sticky_d = sticky_q;
        cls_d    = cls_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
`ifdef FP16_SUBNORMAL_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.in_sign;
                    exp_d    = {{2{bus.in_exp[6]}}, bus.in_exp};
                    mant_d   = bus.in_mant;
                    sticky_d = 1'b0;
`ifdef FP16_SUBNORMAL_EN
                    cnt_d    = 4'd0;
`endif
                    // Specials and zero take one pass through ROUND so the
                    // result register has a single load point.
                    if (bus.in_class == c_cls_normal && (|bus.in_mant)) begin
                        cls_d   = c_cls_normal;
                        state_d = S_NORM;
                    end else begin
                        cls_d   = (bus.in_class == c_cls_normal) ? c_cls_zero : bus.in_class;
                        state_d = S_ROUND;
                    end
                end
            end
            S_NORM: begin
                if (mant_q[MW-1]) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + 9'sd1;
                end else if (!mant_q[MW-2]) begin
                    mant_d   = mant_q << 1;
                    exp_d    = exp_q - 9'sd1;
                end else begin
`ifdef FP16_SUBNORMAL_EN
                    state_d = (exp_q < c_exp_min) ? S_DENORM : S_ROUND;
`else
                    state_d = S_ROUND;
`endif
                end
            end
`ifdef FP16_SUBNORMAL_EN
            S_DENORM: begin
                if (exp_q < c_exp_min && cnt_q != 4'd12) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + 9'sd1;
                    cnt_d    = cnt_q + 4'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
`endif
            S_ROUND: begin
                state_d = S_DONE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inx_d   = 1'b0;
                case (cls_q)
                    c_cls_nan:  result_d = 16'h7E00;
                    c_cls_inf:  result_d = {sign_q, 5'h1F, 10'h000};
                    c_cls_zero: result_d = {sign_q, 15'h0000};
                    default: begin
                        result_d = {sign_q, biased_w[4:0], frac_sum_w[9:0]};
                        inx_d    = inexact_w;
                        if (biased_w >= 9'sd31) begin
                            result_d = {sign_q, 5'h1F, 10'h000};
                            ovf_d    = 1'b1;
                            inx_d    = 1'b1;
                        end else if (biased_w <= 9'sd0) begin
                            result_d = {sign_q, 15'h0000};
                            unf_d    = 1'b1;
                            inx_d    = 1'b1;
                        end
`ifdef FP16_SUBNORMAL_EN
                        if (exp_q < c_exp_min) begin
                            result_d = {sign_q, 15'h0000};
                            ovf_d    = 1'b0;
                            unf_d    = 1'b1;
                            inx_d    = 1'b1;
                        end else if (!mant_q[MW-2]) begin
                            // A rounding carry lands in exponent bit 0: smallest normal.
                            result_d = {sign_q, 4'd0, carry_w, frac_sum_w[9:0]};
                            ovf_d    = 1'b0;
                            unf_d    = inexact_w & ~carry_w;
                            inx_d    = inexact_w;
                        end
`endif
                    end
                endcase
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            sticky_q <= 1'b0;
            cls_q    <= 2'b00;
            result_q <= 16'h0000;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
`ifdef FP16_SUBNORMAL_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            sticky_q <= sticky_d;
            cls_q    <= cls_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
`ifdef FP16_SUBNORMAL_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.in_ready      = (state_q == S_IDLE);
    assign bus.out_valid     = (state_q == S_DONE);
    assign bus.out_result    = result_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_inexact   = inx_q;

endmodule

`default_nettype wire

// File: tb/tb_fp16_quot_normalizer.sv
// ============================================================================
// tb_fp16_quot_normalizer
// Directed and randomized checks of fp16_quot_normalizer against a value-level
// rounding model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp16_quot_normalizer;

    localparam int MW = 24;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    fp16_quot_normalizer_if #(.MW(MW)) bus ();

    fp16_quot_normalizer #(.MW(MW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Value-level model: locate the leading one, round the significand at the
    // binary16 ulp with round-half-even, then classify the biased exponent.
    function automatic void ref_model(input logic s, input int e, input logic [MW-1:0] m,
                                      input logic [1:0] cls, output logic [15:0] res,
                                      output logic ovf, output logic unf, output logic inx,
                                      output int lat);
        int     p;
        int     ex;
        int     sh;
        int     big_e;
        longint kept;
        longint rem;
        longint half;
        ovf = 1'b0; unf = 1'b0; inx = 1'b0; lat = 1; p = -1; res = 16'h0000;
        for (int i = 0; i < MW; i++) if (m[i]) p = i;
        if (cls == 2'b11) begin res = 16'h7E00; return; end
        if (cls == 2'b10) begin res = {s, 5'h1F, 10'h000}; return; end
        if (cls == 2'b01 || p < 0) begin res = {s, 15'h0000}; return; end
        lat   = 2 + ((p > MW-2) ? 1 : (MW-2-p));
        ex    = e + p - (MW-2);
        sh    = p - 10;
        big_e = ex + 15;
`ifdef FP16_SUBNORMAL_EN
        if (big_e < 1) begin
            if (1 - big_e > 12) begin
                lat += 13; res = {s, 15'h0000}; unf = 1'b1; inx = 1'b1;
                return;
            end
            lat += 2 - big_e;
            sh  += 1 - big_e;
        end
`endif
        if (sh <= 0) begin
            kept = longint'(m) << (-sh); rem = 0; half = 1;
        end else begin
            kept = longint'(m) >> sh;
            rem  = longint'(m) & ((64'sd1 << sh) - 1);
            half = 64'sd1 << (sh - 1);
        end
        inx = (rem != 0);
        if (rem > half || (rem == half && kept[0])) kept++;
`ifdef FP16_SUBNORMAL_EN
        if (big_e < 1) begin
            res = {s, kept[14:0]};
            unf = inx && (kept < 1024);
            return;
        end
`endif
        if (kept == 2048) begin kept = 1024; big_e++; end
        if (big_e >= 31) begin
            res = {s, 5'h1F, 10'h000}; ovf = 1'b1; inx = 1'b1;
        end else if (big_e <= 0) begin
            res = {s, 15'h0000}; unf = 1'b1; inx = 1'b1;
        end else begin
            res = {s, big_e[4:0], kept[9:0]};
        end
    endfunction

    task automatic run_op(input logic s, input int e, input logic [MW-1:0] m, input logic [1:0] cls,
                          input logic [15:0] want_res, input logic want_ovf, input logic want_unf,
                          input logic want_inx, input int want_lat, input int hold);
        int lat;
        @(negedge clk);
        check_value("in_ready_idle", bus.in_ready, 1);
        bus.in_sign   = s;
        bus.in_exp    = 7'(e);
        bus.in_mant   = m;
        bus.in_class  = cls;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_value("in_ready_busy", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_value("latency", lat, want_lat);
        check_value("result", bus.out_result, want_res);
        check_value("overflow", bus.out_overflow, want_ovf);
        check_value("underflow", bus.out_underflow, want_unf);
        check_value("inexact", bus.out_inexact, want_inx);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_value("hold_valid", bus.out_valid, 1);
            check_value("hold_result", bus.out_result, want_res);
            check_value("hold_in_ready", bus.in_ready, 0);
        end
        if (hold != 0) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_value("valid_drop", bus.out_valid, 0);
        check_value("in_ready_back", bus.in_ready, 1);
    endtask

    task automatic run_model_op(input logic s, input int e, input logic [MW-1:0] m,
                                input logic [1:0] cls, input int hold);
        logic [15:0] r;
        logic        o;
        logic        u;
        logic        x;
        int          l;
        ref_model(s, e, m, cls, r, o, u, x, l);
        run_op(s, e, m, cls, r, o, u, x, l, hold);
    endtask

    initial begin
        logic          seen;
        logic [MW-1:0] m;
        logic [MW-1:0] mask;
        logic [1:0]    cls;
        int            e;
        int            w;

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 7'd0;
        bus.in_mant   = '0;
        bus.in_class  = 2'b00;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_in_ready", bus.in_ready, 1);
        check_value("rst_out_valid", bus.out_valid, 0);
        check_value("rst_result", bus.out_result, 0);
        check_value("rst_flags", {bus.out_overflow, bus.out_underflow, bus.out_inexact}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(0, 0,   24'h600000, 2'b00, 16'h3E00, 0, 0, 0, 2, 0);
        run_op(0, 0,   24'h200000, 2'b00, 16'h3800, 0, 0, 0, 3, 0);
        run_op(0, 1,   24'hC00000, 2'b00, 16'h4600, 0, 0, 0, 3, 0);
        run_op(0, 0,   24'h7FF800, 2'b00, 16'h4000, 0, 0, 1, 2, 0);
        run_op(0, 0,   24'h400800, 2'b00, 16'h3C00, 0, 0, 1, 2, 0);
        run_op(0, 16,  24'h400000, 2'b00, 16'h7C00, 1, 0, 1, 2, 0);
`ifdef FP16_SUBNORMAL_EN
        run_op(1, -15, 24'h400000, 2'b00, 16'h8200, 0, 0, 0, 4, 0);
`else
        run_op(1, -15, 24'h400000, 2'b00, 16'h8000, 0, 1, 1, 2, 0);
`endif
        run_op(0, 0,   24'h600000, 2'b00, 16'h3E00, 0, 0, 0, 2, 5);
        run_op(1, 5,   24'h123456, 2'b11, 16'h7E00, 0, 0, 0, 1, 0);
        run_op(1, 0,   24'h000000, 2'b10, 16'hFC00, 0, 0, 0, 1, 0);
        run_op(1, 3,   24'h400000, 2'b01, 16'h8000, 0, 0, 0, 1, 0);
        run_op(0, 3,   24'h000000, 2'b00, 16'h0000, 0, 0, 0, 1, 0);

        // Abort a long normalization with reset; nothing may be emitted.
        @(negedge clk);
        bus.in_sign  = 1'b0;
        bus.in_exp   = 7'd0;
        bus.in_mant  = 24'h000001;
        bus.in_class = 2'b00;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_value("abort_out_valid", bus.out_valid, 0);
        check_value("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check_value("abort_no_result", seen, 0);

        for (int n = 0; n < 250; n++) begin
            cls = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) e = int'($urandom_range(0, 127)) - 64;
            else                           e = int'($urandom_range(0, 50)) - 25;
            w = int'($urandom_range(1, MW));
            mask = '0;
            for (int b = 0; b < w; b++) mask[b] = 1'b1;
            m = MW'($urandom) & mask;
            run_model_op(1'($urandom), e, m, cls, ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp16_quot_normalizer.md
Name: fp16_quot_normalizer

Overview:
- Downstream stage of the FP16 divider: takes the raw quotient (sign, unbiased exponent, unnormalized fixed-point mantissa and special-case class).
- Normalizes the mantissa iteratively, one shift per cycle.
- Rounds to nearest-even, re-biases the exponent and packs an IEEE-754 binary16 result with exception flags.
- valid/ready handshake on both sides, one operation in flight.

Parameters:
- MW, 24, raw mantissa width; binary point between bits MW-2 and MW-3 (value = in_mant / 2^(MW-2), range [0,4)); legal 14..40.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream quotient valid
- in_ready  output  1  block can accept (high only in IDLE)
- in_sign  input  1  quotient sign
- in_exp  input  7  signed unbiased exponent (two's complement, -64..63)
- in_mant  input  MW  raw quotient mantissa
- in_class  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  16  packed binary16 {sign, exp[4:0], frac[9:0]}
- out_overflow, out_underflow, out_inexact  output  1 each  exception flags for out_result

Behaviour:
- Reset (async, reset_n low): state IDLE, in_ready=1, out_valid=0, out_result=16'h0000, all flags 0, internal regs cleared. Reset mid-operation aborts it; nothing is emitted.
- Internal exponent: 9-bit signed. Sticky register cleared on capture.
- IDLE: on in_valid&&in_ready, capture all inputs.
  - class normal with mant!=0 -> NORM.
  - class zero, or normal with mant==0 -> DONE with {sign,15'b0}, no flags.
  - infinity -> DONE with {sign,5'h1F,10'b0}.
  - NaN -> DONE with 16'h7E00 (sign ignored).
- NORM (one action per cycle):
  - if mant[MW-1]: shift right 1, sticky|=mant[0], exp+=1.
  - else if !mant[MW-2]: shift left 1, exp-=1.
  - else -> ROUND, or -> DENORM when the optional feature is enabled and exp+15<1.
- ROUND:
  - Fields: frac = mant[MW-3:MW-12], guard G = mant[MW-13], sticky S = OR(mant[MW-14:0]) | sticky.
  - Increment frac when G && (S || frac[0]).
  - Carry out of frac -> frac=0, exp+=1.
  - Biased exponent E = exp+15.
  - E>=31 -> infinity, overflow=1, inexact=1.
  - E<=0 (feature off) -> {sign,15'b0}, underflow=1, inexact=1.
  - Otherwise pack {sign,E[4:0],frac}; inexact = G|S.
  - Next state DONE.
- DONE: out_valid=1; out_result and flags registered and stable until out_valid&&out_ready, then IDLE (in_ready=1 the following cycle; no same-cycle accept).
- Latency (acceptance edge = edge 0):
  - already-normalized input: out_valid high after edge 2; each normalization shift adds one edge.
  - specials/zero: out_valid high after edge 1.
  - Worst case: MW edges.
- in_valid while busy is ignored (in_ready=0); upstream must hold its data.

Optional Feature:
- Macro FP16_SUBNORMAL_EN.
- Enabled: DENORM state.
  - Each cycle while E<1 and fewer than 12 shifts done: shift right 1, sticky|=mant[0], exp+=1.
  - Then ROUND with exponent field 0 (subnormal) when the leading bit is no longer at MW-2.
  - If rounding carries into bit MW-2, E=1 (normal).
  - If 12 shifts are exhausted with E still <1: signed zero, underflow=1, inexact=1.
  - underflow = (result subnormal or zero) && inexact.
- Disabled: no DENORM state; E<=0 flushes to signed zero with underflow=1, inexact=1.

Test Plan:
- sign=0, exp=0, mant=0x600000 (MW=24) -> out_result=0x3E00, flags 0, out_valid after edge 2.
- exp=0, mant=0x200000 -> one left shift -> 0x3800, out_valid after edge 3.
- exp=1, mant=0xC00000 -> one right shift -> 0x4600.
- Rounding:
  - mant=0x7FF800, exp=0 -> round carry -> 0x4000, inexact=1.
  - mant=0x400800 (tie, even) -> 0x3C00, inexact=1.
- Overflow/underflow:
  - exp=16, mant=0x400000 -> 0x7C00, overflow=1.
  - exp=-15, mant=0x400000, sign=1 -> 0x8000, underflow=1 (feature off); 0x8200 (feature on).
- Handshake/reset:
  - Hold out_ready=0 5 cycles -> out_result stable, in_ready=0.
  - Specials: NaN class -> 0x7E00; inf class sign=1 -> 0xFC00.
  - reset_n pulsed low in NORM -> out_valid=0, in_ready=1, no result.
